rah_sha_host_link: RTL

Host-side endpoint of the RAH SHA FIFO link. It accepts one 512-bit block header per request and serializes it into eleven 48-bit words on the write FIFO that feeds the SHA bridge. It then collects the six 48-bit hash chunks the bridge returns through the readback FIFO and presents the reassembled 256-bit hash on a valid/ready response port. It sits between the host/command logic and the FIFO pair in front of the SHA bridge.

---
 rtl/rah_sha_pkg.sv | 21 ++
 rtl/rah_sha_hdr_serializer.sv | 50 +++++
 rtl/rah_sha_host_link.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/rah_sha_pkg.sv
// rtl/rah_sha_pkg.sv - shared widths, counts and state encoding for the RAH SHA host link
package rah_sha_pkg;

  localparam int WORD_W       = 48;
  localparam int HDR_W        = 512;
  localparam int HASH_W       = 256;
  localparam int HDR_WORDS    = 11;
  localparam int HASH_WORDS   = 6;
  localparam int LAST_CHUNK_W = 16;

  localparam int WORD_CNT_W  = 4;
  localparam int CHUNK_CNT_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_RECV = 2'd2,
    ST_RESP = 2'd3
  } state_e;

endpackage

// File: rtl/rah_sha_hdr_serializer.sv
// rtl/rah_sha_hdr_serializer.sv - splits a 512-bit header into eleven 48-bit FIFO words
module rah_sha_hdr_serializer
  import rah_sha_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [HDR_W-1:0]  header,
  input  logic              active,
  input  logic              wr_fifo_full,
  output logic              write_en,
  output logic [WORD_W-1:0] write_data,
  output logic              done
);

  localparam logic [WORD_CNT_W-1:0] LAST_WORD = WORD_CNT_W'(HDR_WORDS - 1);

  logic [HDR_W-1:0]      shreg_q, shreg_d;
  logic [WORD_CNT_W-1:0] word_cnt_q, word_cnt_d;

  // The current word is always the top of the shift register; a full FIFO simply holds it.
  always_comb begin
    write_en   = active && !wr_fifo_full;
    write_data = shreg_q[HDR_W-1 -: WORD_W];
    done       = write_en && (word_cnt_q == LAST_WORD);
    shreg_d    = shreg_q;
    word_cnt_d = word_cnt_q;
    if (load) begin
      shreg_d    = header;
      word_cnt_d = '0;
    end else if (write_en) begin
      shreg_d = {shreg_q[HDR_W-WORD_W-1:0], {WORD_W{1'b0}}};
      if (word_cnt_q != LAST_WORD) begin
        word_cnt_d = word_cnt_q + WORD_CNT_W'(1);
      end
    end
  end

  // Shift register and word counter state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg_q    <= '0;
      word_cnt_q <= '0;
    end else begin
      shreg_q    <= shreg_d;
      word_cnt_q <= word_cnt_d;
    end
  end

endmodule

// File: rtl/rah_sha_host_link.sv
// rtl/rah_sha_host_link.sv - host endpoint: header out over write FIFO, hash back over read FIFO
module rah_sha_host_link
  import rah_sha_pkg::*;
#(
  parameter int RESP_TIMEOUT = 1024
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [HDR_W-1:0]    req_header,
  input  logic                wr_fifo_full,
  output logic                wr_fifo_write_en,
  output logic [WORD_W-1:0]   wr_fifo_write_data,
  input  logic                rd_fifo_empty,
  output logic                rd_fifo_read_en,
  input  logic [WORD_W-1:0]   rd_fifo_read_data,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic [HASH_W-1:0]   resp_hash,
  output logic                busy,
  output logic                timeout_err
);

  localparam int TMO_W = $clog2(RESP_TIMEOUT);
  localparam logic [TMO_W-1:0]       TMO_MAX    = TMO_W'(RESP_TIMEOUT - 1);
  localparam logic [TMO_W-1:0]       TMO_FIRE   = TMO_W'(RESP_TIMEOUT - 2);
  localparam logic [CHUNK_CNT_W-1:0] CHUNK_LAST = CHUNK_CNT_W'(HASH_WORDS - 1);
  localparam logic [CHUNK_CNT_W-1:0] ISSUE_MAX  = CHUNK_CNT_W'(HASH_WORDS);

  state_e                 state_q, state_d;
  logic [CHUNK_CNT_W-1:0] chunk_cnt_q, chunk_cnt_d;
  logic [CHUNK_CNT_W-1:0] issued_cnt_q, issued_cnt_d;
  logic                   pending_q, pending_d;
  logic [TMO_W-1:0]       tmo_cnt_q, tmo_cnt_d;
  logic [HASH_W-1:0]      hash_q, hash_d;
  logic                   timeout_err_q, timeout_err_d;

  logic ser_load;
  logic ser_done;
  logic rd_en;

  assign ser_load = (state_q == ST_IDLE) && req_valid;

  rah_sha_hdr_serializer u_ser (
    .clk          (clk),
    .rst          (rst),
    .load         (ser_load),
    .header       (req_header),
    .active       (state_q == ST_SEND),
    .wr_fifo_full (wr_fifo_full),
    .write_en     (wr_fifo_write_en),
    .write_data   (wr_fifo_write_data),
    .done         (ser_done)
  );

  assign rd_en           = (state_q == ST_RECV) && !rd_fifo_empty && (issued_cnt_q < ISSUE_MAX);
  assign rd_fifo_read_en = rd_en;
  assign req_ready       = (state_q == ST_IDLE) && !rst;
  assign busy            = (state_q != ST_IDLE);
  assign resp_valid      = (state_q == ST_RESP);
  assign resp_hash       = hash_q;
  assign timeout_err     = timeout_err_q;

  // Next-state, readback assembly and response timeout.
  always_comb begin
    state_d       = state_q;
    chunk_cnt_d   = chunk_cnt_q;
    issued_cnt_d  = issued_cnt_q;
    pending_d     = rd_en;
    tmo_cnt_d     = tmo_cnt_q;
    hash_d        = hash_q;
    timeout_err_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          chunk_cnt_d  = '0;
          issued_cnt_d = '0;
          tmo_cnt_d    = '0;
          state_d      = ST_SEND;
        end
      end
      ST_SEND: begin
        if (ser_done) begin
          state_d = ST_RECV;
        end
      end
      ST_RECV: begin
        if (rd_en) begin
          issued_cnt_d = issued_cnt_q + CHUNK_CNT_W'(1);
          tmo_cnt_d    = '0;
        end else if (tmo_cnt_q != TMO_MAX) begin
          tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
        end
        if (pending_q) begin
          // Data of the previous cycle's read lands at the slot for this chunk.
          for (int k = 0; k < HASH_WORDS - 1; k++) begin
            if (chunk_cnt_q == CHUNK_CNT_W'(k)) begin
              hash_d[k*WORD_W +: WORD_W] = rd_fifo_read_data;
            end
          end
          if (chunk_cnt_q == CHUNK_LAST) begin
            hash_d[HASH_W-1 -: LAST_CHUNK_W] = rd_fifo_read_data[LAST_CHUNK_W-1:0];
            state_d = ST_RESP;
          end else begin
            chunk_cnt_d = chunk_cnt_q + CHUNK_CNT_W'(1);
          end
        end else if (!rd_en && tmo_cnt_q == TMO_FIRE) begin
          // Counter reaches its terminal value on this edge; give up on the bridge.
          timeout_err_d = 1'b1;
          state_d       = ST_IDLE;
        end
      end
      ST_RESP: begin
        if (resp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM and datapath registers; reset abandons any in-flight FIFO traffic.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      chunk_cnt_q   <= '0;
      issued_cnt_q  <= '0;
      pending_q     <= 1'b0;
      tmo_cnt_q     <= '0;
      hash_q        <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      chunk_cnt_q   <= chunk_cnt_d;
      issued_cnt_q  <= issued_cnt_d;
      pending_q     <= pending_d;
      tmo_cnt_q     <= tmo_cnt_d;
      hash_q        <= hash_d;
      timeout_err_q <= timeout_err_d;
    end
  end

endmodule
